// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60Hz raster timing, 12-bit RGB colours and the
// pixel-window helper used by the downstream colour logic.
package vga_pkg;

   localparam int unsigned VGA_CLK_DIV      = 4;
   localparam int unsigned VGA_H_SYNC       = 96;
   localparam int unsigned VGA_H_DISP_START = 144;
   localparam int unsigned VGA_H_DISP_END   = 784;
   localparam int unsigned VGA_H_TOTAL      = 800;
   localparam int unsigned VGA_V_SYNC       = 2;
   localparam int unsigned VGA_V_DISP_START = 35;
   localparam int unsigned VGA_V_DISP_END   = 515;
   localparam int unsigned VGA_V_TOTAL      = 525;

   localparam int unsigned COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [11:0]        rgb_t;

   localparam rgb_t RGB_BLACK  = 12'h000;
   localparam rgb_t RGB_WHITE  = 12'hFFF;
   localparam rgb_t RGB_RED    = 12'hF00;
   localparam rgb_t RGB_GREEN  = 12'h0F0;
   localparam rgb_t RGB_BLUE   = 12'h00F;
   localparam rgb_t RGB_YELLOW = 12'hFF0;

   // Half-open window test: x0 <= h < x1 and y0 <= v < y1.
   function automatic logic in_window(input coord_t h, input coord_t v,
                                      input coord_t x0, input coord_t x1,
                                      input coord_t y0, input coord_t y1);
      return (h >= x0) && (h < x1) && (v >= y0) && (v < y1);
   endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clk_en.sv
// Pixel-rate divider: o_advance is the combinational "last divider cycle" flag the
// counters step on; o_pixel_en is its registered copy, aligned with the new position.
module pixel_clk_en
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_advance,
   output logic o_pixel_en
);

   localparam int unsigned DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] r_div;
   logic          r_pixel_en;
   logic          w_advance;

   // >= so an out-of-range divider value (non power-of-two CLK_DIV) still wraps.
   assign w_advance  = (r_div >= LAST);
   assign o_advance  = w_advance;
   assign o_pixel_en = r_pixel_en;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div      <= '0;
         r_pixel_en <= 1'b0;
      end else begin
         r_div      <= w_advance ? '0 : r_div + 1'b1;
         r_pixel_en <= w_advance;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: position counters plus registered sync/bright/tick
// decode, all computed from the next position so they change together with the counters.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV      = VGA_CLK_DIV,
   parameter int unsigned H_SYNC       = VGA_H_SYNC,
   parameter int unsigned H_DISP_START = VGA_H_DISP_START,
   parameter int unsigned H_DISP_END   = VGA_H_DISP_END,
   parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
   parameter int unsigned V_SYNC       = VGA_V_SYNC,
   parameter int unsigned V_DISP_START = VGA_V_DISP_START,
   parameter int unsigned V_DISP_END   = VGA_V_DISP_END,
   parameter int unsigned V_TOTAL      = VGA_V_TOTAL
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pixel_en,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright,
   output logic       line_tick,
   output logic       frame_tick
);

   localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
   localparam coord_t H_SW   = coord_t'(H_SYNC);
   localparam coord_t V_SW   = coord_t'(V_SYNC);
   localparam coord_t H_DS   = coord_t'(H_DISP_START);
   localparam coord_t H_DE   = coord_t'(H_DISP_END);
   localparam coord_t V_DS   = coord_t'(V_DISP_START);
   localparam coord_t V_DE   = coord_t'(V_DISP_END);

   logic   w_adv;
   logic   w_h_wrap;
   logic   w_v_wrap;
   coord_t w_h_next;
   coord_t w_v_next;

   coord_t r_h;
   coord_t r_v;
   logic   r_hsync;
   logic   r_vsync;
   logic   r_bright;
   logic   r_line_tick;
   logic   r_frame_tick;

   pixel_clk_en #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_clk_en (
      .i_clk      (clk),
      .i_rst_n    (rst),
      .o_advance  (w_adv),
      .o_pixel_en (pixel_en)
   );

   // >= comparisons let a corrupted (out-of-range) count fall back to 0.
   assign w_h_wrap = (r_h >= H_LAST);
   assign w_v_wrap = (r_v >= V_LAST);

   always_comb begin
      w_h_next = r_h;
      w_v_next = r_v;
      if (w_adv) begin
         w_h_next = w_h_wrap ? '0 : r_h + 1'b1;
         if (r_v > V_LAST)
            w_v_next = '0;
         else if (w_h_wrap)
            w_v_next = w_v_wrap ? '0 : r_v + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h          <= '0;
         r_v          <= '0;
         r_hsync      <= 1'b0;
         r_vsync      <= 1'b0;
         r_bright     <= 1'b0;
         r_line_tick  <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_h          <= w_h_next;
         r_v          <= w_v_next;
         r_hsync      <= (w_h_next >= H_SW);
         r_vsync      <= (w_v_next >= V_SW);
         r_bright     <= in_window(w_h_next, w_v_next, H_DS, H_DE, V_DS, V_DE);
         r_line_tick  <= w_adv && w_h_wrap;
         r_frame_tick <= w_adv && w_h_wrap && w_v_wrap;
      end
   end

   assign hCount     = r_h;
   assign vCount     = r_v;
   assign hSync      = r_hsync;
   assign vSync      = r_vsync;
   assign bright     = r_bright;
   assign line_tick  = r_line_tick;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for reset/line checks and a shrunken
// CLK_DIV=2 instance for frame, bright-window and mid-frame-reset checks.
module tb_vga_timing_gen;

   localparam int unsigned F_CD = 4, F_HS = 96, F_HDS = 144, F_HDE = 784, F_HT = 800;
   localparam int unsigned F_VS = 2, F_VDS = 35, F_VDE = 515, F_VT = 525;
   localparam int unsigned S_CD = 2, S_HS = 3, S_HDS = 5, S_HDE = 13, S_HT = 16;
   localparam int unsigned S_VS = 2, S_VDS = 3, S_VDE = 9, S_VT = 11;

   typedef struct packed {
      logic       pe;
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       br;
      logic       lt;
      logic       ft;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       f_pe, f_hs, f_vs, f_br, f_lt, f_ft;
   logic [9:0] f_h, f_v;
   logic       s_pe, s_hs, s_vs, s_br, s_lt, s_ft;
   logic [9:0] s_h, s_v;
   obs_t       obs_f, obs_s;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int unsigned cyc    = 0;

   vga_timing_gen u_full (
      .clk(clk), .rst(rst), .pixel_en(f_pe), .hCount(f_h), .vCount(f_v),
      .hSync(f_hs), .vSync(f_vs), .bright(f_br), .line_tick(f_lt), .frame_tick(f_ft)
   );

   vga_timing_gen #(
      .CLK_DIV(S_CD), .H_SYNC(S_HS), .H_DISP_START(S_HDS), .H_DISP_END(S_HDE),
      .H_TOTAL(S_HT), .V_SYNC(S_VS), .V_DISP_START(S_VDS), .V_DISP_END(S_VDE),
      .V_TOTAL(S_VT)
   ) u_small (
      .clk(clk), .rst(rst), .pixel_en(s_pe), .hCount(s_h), .vCount(s_v),
      .hSync(s_hs), .vSync(s_vs), .bright(s_br), .line_tick(s_lt), .frame_tick(s_ft)
   );

   assign obs_f = {f_pe, f_h, f_v, f_hs, f_vs, f_br, f_lt, f_ft};
   assign obs_s = {s_pe, s_h, s_v, s_hs, s_vs, s_br, s_lt, s_ft};

   always #5 clk = ~clk;

   // Clock edges since reset release; the model derives everything from this.
   always @(posedge clk or negedge rst) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   function automatic obs_t model(input int unsigned c, input int unsigned cd,
                                  input int unsigned hs, input int unsigned hds,
                                  input int unsigned hde, input int unsigned ht,
                                  input int unsigned vs, input int unsigned vds,
                                  input int unsigned vde, input int unsigned vt);
      obs_t m;
      int unsigned p, h, v;
      p    = c / cd;
      h    = p % ht;
      v    = (p / ht) % vt;
      m.pe = (c != 0) && (c % cd == 0);
      m.h  = 10'(h);
      m.v  = 10'(v);
      m.hs = (h >= hs);
      m.vs = (v >= vs);
      m.br = (h >= hds) && (h < hde) && (v >= vds) && (v < vde);
      m.lt = m.pe && (h == 0);
      m.ft = m.lt && (v == 0);
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      check("model_full", 32'(obs_f),
            32'(model(cyc, F_CD, F_HS, F_HDS, F_HDE, F_HT, F_VS, F_VDS, F_VDE, F_VT)));
      check("model_small", 32'(obs_s),
            32'(model(cyc, S_CD, S_HS, S_HDS, S_HDE, S_HT, S_VS, S_VDS, S_VDE, S_VT)));
   end

   // Per-frame / per-line statistics of the small instance.
   logic        s_map [0:15][0:15];
   int unsigned s_bcnt = 0, s_bright_last = 0, s_vscnt = 0, s_vs_last = 0;
   int unsigned s_fgap = 0, s_fper = 0, s_lgap = 0, s_lper = 0;
   int unsigned f_hslow = 0;

   always @(negedge clk) begin
      s_map[s_v[3:0]][s_h[3:0]] <= s_br;
      if (s_ft) begin
         s_bright_last <= s_bcnt;
         s_bcnt        <= 0;
         s_vs_last     <= s_vscnt;
         s_vscnt       <= s_vs ? 0 : 1;
         s_fper        <= s_fgap;
         s_fgap        <= 1;
      end else begin
         if (s_pe && s_br)  s_bcnt  <= s_bcnt + 1;
         if (s_lt && !s_vs) s_vscnt <= s_vscnt + 1;
         s_fgap <= s_fgap + 1;
      end
      if (s_lt) begin
         s_lper <= s_lgap;
         s_lgap <= 1;
      end else begin
         s_lgap <= s_lgap + 1;
      end
      if (f_pe && f_v == 10'd1 && !f_hs) f_hslow <= f_hslow + 1;
   end

   int corner [8][3] = '{'{5, 3, 1}, '{12, 3, 1}, '{5, 8, 1}, '{12, 8, 1},
                         '{4, 3, 0}, '{13, 3, 0}, '{5, 2, 0}, '{5, 9, 0}};

   initial begin
      logic        found;
      int unsigned n;

      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("reset_full", 32'(obs_f), 0);
      check("reset_small", 32'(obs_s), 0);
      rst = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("pe_clk3", 32'(f_pe), 0);
      check("h_clk3", 32'(f_h), 0);
      @(posedge clk);
      #1;
      check("pe_clk4", 32'(f_pe), 1);
      check("h_clk4", 32'(f_h), 1);
      check("small_h_clk4", 32'(s_h), 2);

      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (f_lt) begin found = 1'b1; break; end
      end
      check("line_wrap_seen", 32'(found), 1);
      check("line_wrap_at_clk", cyc, 3200);
      check("line_wrap_v", 32'(f_v), 1);
      check("line_wrap_h", 32'(f_h), 0);
      check("line_wrap_no_ft", 32'(f_ft), 0);
      @(posedge clk);
      #1;
      check("line_tick_width", 32'(f_lt), 0);

      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (f_lt && f_v == 10'd2) begin found = 1'b1; break; end
      end
      check("line2_seen", 32'(found), 1);
      check("hsync_low_pixels", f_hslow, 96);

      check("small_bright_per_frame", s_bright_last, 48);
      check("small_vsync_lines", s_vs_last, 2);
      check("small_line_period_clk", s_lper, 32);
      check("small_frame_period_clk", s_fper, 352);
      for (int i = 0; i < 8; i++)
         check($sformatf("bright_at_%0d_%0d", corner[i][0], corner[i][1]),
               32'(s_map[corner[i][1]][corner[i][0]]), 32'(corner[i][2]));

      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (s_ft) begin found = 1'b1; break; end
      end
      check("small_ft_seen", 32'(found), 1);
      check("small_ft_with_lt", 32'(s_lt), 1);
      check("small_ft_pos", 32'({s_h, s_v}), 0);

      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (s_h == 10'd8 && s_v == 10'd6) begin found = 1'b1; break; end
      end
      check("midframe_pos_seen", 32'(found), 1);
      #2 rst = 1'b0;
      #1;
      check("midrst_full", 32'(obs_f), 0);
      check("midrst_small", 32'(obs_s), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      found = 1'b0;
      n     = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (s_ft) begin found = 1'b1; n = i + 1; break; end
      end
      check("restart_ft_seen", 32'(found), 1);
      check("restart_first_ft_clk", n, 352);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
